// File: rtl/datapath_check_pkg.sv
// Shared definitions for the datapath write/readback check blocks.
package datapath_check_pkg;

   localparam int unsigned REG_SEL_W      = 4;
   localparam int unsigned MISMATCH_CNT_W = 5;

   localparam logic [MISMATCH_CNT_W-1:0] MISMATCH_SAT = 5'd16;

   localparam logic [15:0] DEFAULT_SEED0 = 16'd1;
   localparam logic [15:0] DEFAULT_SEED1 = 16'd1;

   typedef enum logic [2:0] {
      StIdle,
      StSel,
      StWait,
      StCmp,
      StDone
   } check_state_e;

   function automatic logic [MISMATCH_CNT_W-1:0] sat_inc(input logic [MISMATCH_CNT_W-1:0] v);
      if (v >= MISMATCH_SAT) begin
         return v;
      end
      return v + MISMATCH_CNT_W'(1);
   endfunction

endpackage

// File: rtl/fibonacci_expected_gen.sv
// Fibonacci reference generator: expected presents e(n); advance steps to e(n+1), mod 2^DATA_WIDTH.
module fibonacci_expected_gen
   import datapath_check_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 16,
   parameter logic [DATA_WIDTH-1:0] SEED0      = DATA_WIDTH'(DEFAULT_SEED0),
   parameter logic [DATA_WIDTH-1:0] SEED1      = DATA_WIDTH'(DEFAULT_SEED1)
) (
   input  logic                  I_CLK,
   input  logic                  I_NRESET,
   input  logic                  load,
   input  logic                  advance,
   output logic [DATA_WIDTH-1:0] expected
);

   logic [DATA_WIDTH-1:0] cur_q, cur_d;
   logic [DATA_WIDTH-1:0] nxt_q, nxt_d;

   always_comb begin
      cur_d = cur_q;
      nxt_d = nxt_q;
      if (load) begin
         cur_d = SEED0;
         nxt_d = SEED1;
      end else if (advance) begin
         cur_d = nxt_q;
         nxt_d = cur_q + nxt_q;
      end
   end

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         cur_q <= SEED0;
         nxt_q <= SEED1;
      end else begin
         cur_q <= cur_d;
         nxt_q <= nxt_d;
      end
   end

   assign expected = cur_q;

endmodule

// File: rtl/datapath_readback_checker.sv
// Walks regfile r0..r(NUM_REGS-1) through the datapath A port and checks each word against a
// Fibonacci reference, reporting pass/fail, the first mismatch and a saturating mismatch count.
module datapath_readback_checker
   import datapath_check_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH   = 16,
   parameter int unsigned           NUM_REGS     = 8,
   parameter logic [DATA_WIDTH-1:0] SEED0        = DATA_WIDTH'(DEFAULT_SEED0),
   parameter logic [DATA_WIDTH-1:0] SEED1        = DATA_WIDTH'(DEFAULT_SEED1),
   parameter int unsigned           READ_LATENCY = 1,
   parameter int unsigned           STOP_ON_FAIL = 0
) (
   input  logic                      I_CLK,
   input  logic                      I_NRESET,
   input  logic                      I_START,
   input  logic [DATA_WIDTH-1:0]     I_REG_DATA,
   output logic [REG_SEL_W-1:0]      O_REG_A_SELECT,
   output logic                      O_BUSY,
   output logic                      O_DONE,
   output logic                      O_PASS,
   output logic [REG_SEL_W-1:0]      O_FAIL_INDEX,
   output logic [DATA_WIDTH-1:0]     O_FAIL_VALUE,
   output logic [MISMATCH_CNT_W-1:0] O_MISMATCH_COUNT
);

   localparam int unsigned          LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [LAT_W-1:0]     LAT_LAST = LAT_W'(READ_LATENCY - 1);
   localparam logic [REG_SEL_W-1:0] IDX_LAST = REG_SEL_W'(NUM_REGS - 1);

   check_state_e                state_q, state_d;
   logic [REG_SEL_W-1:0]        idx_q, idx_d;
   logic [LAT_W-1:0]            lat_q, lat_d;
   logic [MISMATCH_CNT_W-1:0]   count_q, count_d;
   logic [REG_SEL_W-1:0]        fail_idx_q, fail_idx_d;
   logic [DATA_WIDTH-1:0]       fail_val_q, fail_val_d;

   logic                  gen_load;
   logic                  gen_advance;
   logic [DATA_WIDTH-1:0] expected;
   logic                  mismatch;
   logic                  last_reg;

   fibonacci_expected_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEED0      (SEED0),
      .SEED1      (SEED1)
   ) u_expected_gen (
      .I_CLK    (I_CLK),
      .I_NRESET (I_NRESET),
      .load     (gen_load),
      .advance  (gen_advance),
      .expected (expected)
   );

   assign mismatch = (I_REG_DATA != expected);
   assign last_reg = (idx_q == IDX_LAST);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      lat_d       = lat_q;
      count_d     = count_q;
      fail_idx_d  = fail_idx_q;
      fail_val_d  = fail_val_q;
      gen_load    = 1'b0;
      gen_advance = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (I_START) begin
               state_d    = StSel;
               idx_d      = '0;
               count_d    = '0;
               fail_idx_d = '0;
               fail_val_d = '0;
               gen_load   = 1'b1;
            end
         end
         StSel: begin
            state_d = StWait;
            lat_d   = '0;
         end
         StWait: begin
            if (lat_q == LAT_LAST) begin
               state_d = StCmp;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         StCmp: begin
            if (mismatch) begin
               count_d = sat_inc(count_q);
               // Count never returns to zero mid-check, so zero marks the first mismatch.
               if (count_q == '0) begin
                  fail_idx_d = idx_q;
                  fail_val_d = I_REG_DATA;
               end
            end
            if (last_reg || ((STOP_ON_FAIL != 0) && mismatch)) begin
               state_d = StDone;
            end else begin
               state_d     = StSel;
               idx_d       = idx_q + REG_SEL_W'(1);
               gen_advance = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         lat_q      <= '0;
         count_q    <= '0;
         fail_idx_q <= '0;
         fail_val_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         lat_q      <= lat_d;
         count_q    <= count_d;
         fail_idx_q <= fail_idx_d;
         fail_val_q <= fail_val_d;
      end
   end

   assign O_REG_A_SELECT   = idx_q;
   assign O_BUSY           = (state_q == StSel) || (state_q == StWait) || (state_q == StCmp);
   assign O_DONE           = (state_q == StDone);
   assign O_PASS           = (state_q == StDone) && (count_q == '0);
   assign O_FAIL_INDEX     = fail_idx_q;
   assign O_FAIL_VALUE     = fail_val_q;
   assign O_MISMATCH_COUNT = count_q;

endmodule
